// File: rtl/gf163_exp_ctrl.sv
// gf163_exp_ctrl: left-to-right square-and-multiply a^e over GF(2^163), x^163+x^7+x^6+x^3+1.
// Optional multiplier output register: define GF163_MUL_PIPE_EN.
module karatsuba_163x163 (
    input  logic [162:0] a,
    input  logic [162:0] b,
    output logic [162:0] c
);
    logic [162:0] p;
    always_comb begin
        p = '0;
        for (int i = 162; i >= 0; i--)
            p = {p[161:0], 1'b0} ^ (p[162] ? 163'hC9 : 163'h0) ^ (b[i] ? a : 163'h0);
    end
    assign c = p;
endmodule

module gf163_exp_ctrl #(
    parameter int E_W = 163
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [162:0]   a,
    input  logic [E_W-1:0] e,
    output logic           busy,
    output logic           done,
    output logic [162:0]   r
);
    localparam int IW = $clog2(E_W) + 1;
    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;
    state_t state_q, state_d;
    logic [162:0] base_q, base_d, acc_q, acc_d, r_q, r_d, mul_b, mul_c, prod;
    logic [E_W-1:0] exp_q, exp_d;
    logic [IW-1:0] idx_q, idx_d;
    logic exp_bit, wb;
`ifdef GF163_MUL_PIPE_EN
    logic ph_q, ph_d;
    logic [162:0] prod_q;
    assign prod = prod_q;
    assign wb = ph_q;
`else
    assign prod = mul_c;
    assign wb = 1'b1;
`endif
    assign mul_b = (state_q == MUL) ? base_q : acc_q;
    assign exp_bit = |(exp_q & (E_W'(1) << idx_q));
    karatsuba_163x163 u_mul (.a(acc_q), .b(mul_b), .c(mul_c));
    always_comb begin
        state_d = state_q;
        base_d = base_q;
        exp_d = exp_q;
        acc_d = acc_q;
        idx_d = idx_q;
        r_d = r_q;
`ifdef GF163_MUL_PIPE_EN
        ph_d = ph_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                base_d = a;
                exp_d = e;
                acc_d = 163'd1;
                idx_d = IW'(E_W - 1);
                state_d = SQR;
            end
            SQR, MUL: begin
`ifdef GF163_MUL_PIPE_EN
                ph_d = ~ph_q;
`endif
                if (wb) begin
                    acc_d = prod;
                    if (state_q == SQR && exp_bit) state_d = MUL;
                    else if (idx_q == '0) begin
                        state_d = DONE;
                        r_d = prod;
                    end else begin
                        idx_d = idx_q - 1'b1;
                        state_d = SQR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q <= '0;
            exp_q <= '0;
            acc_q <= '0;
            idx_q <= '0;
            r_q <= '0;
        end else begin
            state_q <= state_d;
            base_q <= base_d;
            exp_q <= exp_d;
            acc_q <= acc_d;
            idx_q <= idx_d;
            r_q <= r_d;
        end
    end
`ifdef GF163_MUL_PIPE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q <= 1'b0;
            prod_q <= '0;
        end else begin
            ph_q <= ph_d;
            prod_q <= mul_c;
        end
    end
`endif
    assign busy = (state_q == SQR) || (state_q == MUL);
    assign done = (state_q == DONE);
    assign r = r_q;
endmodule

// File: doc/gf163_exp_ctrl.md
Name: gf163_exp_ctrl

Overview:
- Sequential exponentiation controller for GF(2^163).
- Computes r = a^e by left-to-right square-and-multiply over a single shared instance of the combinational karatsuba_163x163 multiplier, ports (a,b,c).
- Field reduction happens entirely inside the multiplier. This block only sequences operands, the accumulator and the start/busy/done handshake.
- Used for field inversion (e = 2^163-2) and general powers by higher-level point arithmetic.

Parameters:
- E_W, 163, exponent width in bits. Legal range 1..163.

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request. Sampled only in IDLE.
- a  input  163  base operand, latched on accepted start
- e  input  E_W  exponent, latched on accepted start
- busy  output  1  high while an exponentiation is in progress
- done  output  1  one-cycle pulse when r becomes valid
- r  output  163  result. Held stable from done until the next accepted start.

Behaviour:
- Reset is synchronous and active-high on clk. rst=1 at an edge forces:
  - state=IDLE, busy=0, done=0, r=0
  - accumulator=0, base=0, exp register=0, bit index=0
- Reset mid-operation aborts with no done pulse. The same reset values apply.
- Internal registers:
  - base[162:0], exp[E_W-1:0], acc[162:0]
  - idx, bit index of width clog2(E_W)+1
- Multiplier operands are driven from registers only:
  - SQR state: (acc, acc)
  - MUL state: (acc, base)
- States: IDLE, SQR, MUL, DONE.
- IDLE:
  - busy=0.
  - On start=1: base<=a, exp<=e, acc<=1, idx<=E_W-1, go to SQR.
- SQR:
  - acc<=acc*acc.
  - If exp[idx]=1, go to MUL.
  - Else if idx=0, go to DONE.
  - Else idx<=idx-1 and stay in SQR.
- MUL:
  - acc<=acc*base.
  - If idx=0, go to DONE.
  - Else idx<=idx-1, go to SQR.
- DONE:
  - r<=acc and done=1 for exactly this one cycle. busy=0 in this cycle.
  - Go to IDLE.
- busy=1 in SQR and MUL only.
- Latency from the start edge to the done cycle: E_W + popcount(e) + 1 clock cycles, with no data dependence beyond popcount.
  - E_W=163, e=0: done appears 164 cycles after start.
- Leading zero exponent bits are not skipped. Squaring 1 yields 1.
- Boundary conditions:
  - e=0 gives r=1, including when a=0.
  - a=0, e≠0 gives r=0.
  - start while busy or in DONE is ignored. It is not queued.
  - start and rst high together: rst wins.
  - Inputs a and e may change freely after the accepting edge.
- r retains its previous value during an operation. It is updated only in DONE.

Optional Feature:
- Macro: GF163_MUL_PIPE_EN.
- Defined:
  - A 163-bit register sits on the multiplier output.
  - Each SQR/MUL state splits into an issue cycle and a write-back cycle.
  - Operands are held stable across both cycles.
  - acc updates on the write-back cycle only.
  - Latency becomes 2*(E_W + popcount(e)) + 1 cycles.
  - All other handshake rules are unchanged.
- Undefined: single-cycle multiply as specified above. No extra register.

Test Plan:
- E_W=163, a=163'h2, e=1 -> done after 165 cycles, r=163'h2. busy high for exactly 164 cycles.
- a=163'h2, e=2 -> r=163'h4. a=163'h2, e=162 -> r=163'h40000000000000000000000000000000000000000.
- a=0 with e=0, and a=163'h7fff…f with e=0 -> r=163'h1 after 164 cycles.
- a=163'h2 with e=2^163-1 (all ones), and a=163'h8000000000000000000000000000000000000001 with e=2^163-1 -> r=1. Latency 327 cycles.
- a=163'h2, e=2^163-2 -> r=x^-1. Feeding r and 163'h2 into a standalone karatsuba_163x163 gives c=163'h1.
- Control:
  - Pulse start again 10 cycles into an operation -> ignored, result unchanged.
  - Assert rst at cycle 50 of an operation -> next cycle busy=0, done=0, r=0, no done pulse.
  - A fresh start afterwards completes correctly.
- Repeat all of the above with GF163_MUL_PIPE_EN defined. Check the doubled latency: 329 cycles for the a=2, e=1 case.
